// File: rtl/pipelined_addsub.sv
// Carry-chained pipelined W-bit adder/subtractor. Each stage resolves one CW-bit chunk.
// A global advance (!out_valid || out_ready) stalls every stage together.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic             adv;
  logic             acc;
  logic [WIDTH-1:0] bx;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;
  assign acc      = in_valid && in_ready;
  assign bx       = sub ? ~b : b;

  for (genvar i = 0; i < STAGES; i++) begin : g
    localparam int unsigned LO = i * CW;      // result bits resolved before this stage
    localparam int unsigned RW = WIDTH - LO;  // operand bits still unprocessed on entry

    logic             vin;
    logic [RW-1:0]    ain;
    logic [RW-1:0]    bin;
    logic             cin;
    logic [CW:0]      csum;
    logic [LO+CW-1:0] snext;

    logic             v_q;
    logic [LO+CW-1:0] s_q;
    logic             c_q;

    assign csum = {1'b0, ain[CW-1:0]} + {1'b0, bin[CW-1:0]} + {{CW{1'b0}}, cin};

    if (i == 0) begin : src
      assign vin   = acc;
      assign ain   = a;
      assign bin   = bx;
      assign cin   = sub;
      assign snext = csum[CW-1:0];
    end else begin : src
      assign vin   = g[i-1].v_q;
      assign ain   = g[i-1].rest.a_q;
      assign bin   = g[i-1].rest.b_q;
      assign cin   = g[i-1].c_q;
      assign snext = {csum[CW-1:0], g[i-1].s_q};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= vin;
        s_q <= snext;
        c_q <= csum[CW];
      end
    end

    if (i < STAGES - 1) begin : rest
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= ain[RW-1:CW];
          b_q <= bin[RW-1:CW];
        end
      end
    end else begin : fin
      logic cmsb;
      logic ovf_q;
      logic zero_q;

      // carry into the MSB recovered from the MSB sum bit and its operands
      assign cmsb = ain[CW-1] ^ bin[CW-1] ^ csum[CW-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= cmsb ^ csum[CW];
          zero_q <= (snext == '0);
        end
      end
    end
  end

  assign out_valid = g[STAGES-1].v_q;
  assign sum       = g[STAGES-1].s_q;
  assign carryout  = g[STAGES-1].c_q;
  assign overflow  = g[STAGES-1].fin.ovf_q;
  assign zero      = g[STAGES-1].fin.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations (32/4, 32/1, 8/8) against an
// arithmetic reference model; directed vectors, latency, streaming with stalls, reset flush.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        sub;
  logic [2:0]  iv, ordy, rdy, ov, co, of, zr;
  logic [31:0] sm0, sm1;
  logic [7:0]  sm8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm0), .carryout(co[0]), .overflow(of[0]),
    .zero(zr[0]));

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm1), .carryout(co[1]), .overflow(of[1]),
    .zero(zr[1]));

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]), .a(a[7:0]), .b(b[7:0]),
    .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm8), .carryout(co[2]),
    .overflow(of[2]), .zero(zr[2]));

  function automatic int unsigned wid(int d);
    return (d == 2) ? 8 : 32;
  endfunction

  function automatic int stg(int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  function automatic res_t observed(int d);
    res_t o;
    case (d)
      0:       o = '{sum: sm0, c: co[0], v: of[0], z: zr[0]};
      1:       o = '{sum: sm1, c: co[1], v: of[1], z: zr[1]};
      default: o = '{sum: {24'b0, sm8}, c: co[2], v: of[2], z: zr[2]};
    endcase
    return o;
  endfunction

  // Reference: plain unsigned/signed integer arithmetic on 64-bit values
  function automatic res_t model(int unsigned w, logic [31:0] av, logic [31:0] bv, logic s);
    longint m, half, ua, ub, sa, sb, r, sr;
    res_t o;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'b0, av}) & m;
    ub   = longint'({32'b0, bv}) & m;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    r    = s ? ua - ub : ua + ub;
    sr   = s ? sa - sb : sa + sb;
    o.sum = 32'(r & m);
    o.c   = s ? (ua >= ub) : (r > m);
    o.v   = (sr >= half) || (sr < -half);
    o.z   = ((r & m) == 0);
    return o;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat with out_ready high; measures edges from acceptance to out_valid.
  task automatic dir_vec(int d, logic [31:0] av, logic [31:0] bv, logic s, string tag);
    int n;
    chk({tag, "_ready"}, rdy[d], 1);
    a = av; b = bv; sub = s; ordy[d] = 1'b1; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (ov[d] || n >= 20) break;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, stg(d));
    chk({tag, "_res"}, observed(d), model(wid(d), av, bv, s));
    @(posedge clk); #1;
  endtask

  task automatic stream(int d, int n, bit rnd);
    res_t q[$];
    res_t held, obs, e;
    bit   stalled = 1'b0;
    int   sent = 0, recv = 0, it = 0;
    while ((sent < n || recv < n) && it < 4000) begin
      iv[d]   = (sent < n) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      a       = $urandom;
      b       = $urandom;
      sub     = 1'($urandom_range(1));
      ordy[d] = rnd ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      obs = observed(d);
      if (stalled) begin
        chk("hold_valid", ov[d], 1);
        chk("hold_data", obs, held);
      end
      if (ov[d] && !ordy[d]) chk("stall_in_ready", rdy[d], 0);
      if (ov[d] && ordy[d]) begin
        if (q.size() == 0) chk("spurious_out", ov[d], 0);
        else begin
          e = q.pop_front();
          chk("stream_res", obs, e);
          recv++;
        end
      end
      if (iv[d] && rdy[d]) begin
        q.push_back(model(wid(d), a, b, sub));
        sent++;
      end
      stalled = ov[d] && !ordy[d];
      held    = obs;
      @(posedge clk); #1;
      it++;
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    chk("stream_done", recv, n);
    if (!rnd) chk("throughput_cycles", it, n + stg(d));
  endtask

  logic [31:0] va32 [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  logic [31:0] vb32 [6] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd0};
  logic [31:0] va8  [6] = '{32'hFF, 32'h7F, 32'h0F, 32'd5, 32'h80, 32'd0};
  logic [31:0] vb8  [6] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd0};
  logic        vs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int bad;
    reset = 1'b1;
    iv    = 3'b001;
    ordy  = '1;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_in_ready", rdy[0], 0);
    chk("reset_out_valid", ov, 0);
    chk("reset_outputs", observed(0), '0);
    chk("reset_outputs_w8", observed(2), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    iv    = '0;
    @(negedge clk);
    chk("post_reset_in_ready", rdy, 3'b111);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    chk("ignored_during_reset", ov, 0);

    // Spot-check the reference against hand-derived constants
    chk("model_wrap", model(32, 32'hFFFF_FFFF, 32'd1, 1'b0), {32'h0, 1'b1, 1'b0, 1'b1});
    chk("model_borrow", model(32, 32'd5, 32'd7, 1'b1), {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) begin
        if (d == 2) dir_vec(d, va8[k], vb8[k], vs[k], $sformatf("dir_d%0d_v%0d", d, k));
        else        dir_vec(d, va32[k], vb32[k], vs[k], $sformatf("dir_d%0d_v%0d", d, k));
      end
    end

    stream(0, 100, 1'b1);
    stream(0, 20, 1'b0);
    stream(1, 30, 1'b1);
    stream(1, 20, 1'b0);
    stream(2, 30, 1'b1);
    stream(2, 20, 1'b0);

    // Reset mid-stream: three beats in flight are discarded
    ordy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(1));
      iv[0] = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    iv[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov[0]) bad++;
      @(posedge clk); #1;
    end
    chk("reset_flush", bad, 0);
    dir_vec(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised W-bit integer adder/subtractor built as a carry-chained pipeline: the operand is split into STAGES equal chunks, and one chunk is resolved per stage with the carry registered between stages. It generalises the single-bit full adder to arbitrary width with an add/subtract mode, status flags, and a valid/ready stream interface with backpressure. It sits in the FPU datapath as the shared integer engine for mantissa add/subtract and exponent arithmetic.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES=1 is legal.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carryout  output  1  carry out of the MSB. For subtraction, 1 means no borrow (A ≥ B unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- Subtraction uses B' = ~b with carry-in 1; addition uses B' = b with carry-in 0.
- Stage i (0..STAGES−1) adds chunk i of A and B' plus the carry registered by stage i−1 (stage 0 uses the mode carry-in). It registers the chunk sum, the carry out, and the still-unprocessed upper chunks of A and B'. Lower result chunks already computed travel with the beat.
- overflow = carry into MSB XOR carry out of MSB. It is computed in the final stage and is equivalent to (A[msb]==B'[msb]) && (sum[msb]!=A[msb]).
- zero is computed in the final stage from the full sum.
- Each stage carries a valid bit. Bubbles propagate and are not collapsed.
- Global advance: adv = !out_valid || out_ready. All stages shift only when adv=1; otherwise every stage holds.
- in_ready = adv && !reset. This is combinational from out_ready and out_valid, with no register in the path.
- A beat is accepted on an edge where in_valid && in_ready.
- While out_valid && !out_ready, sum, carryout, overflow and zero are held stable.
- When out_valid=0, the data outputs are don't-care, except after reset.

## Timing
- Reset (synchronous): all stage valid bits, out_valid, sum, carryout, overflow and zero go to 0. in_ready is 0 during the reset cycle and 1 on the first cycle after reset is released. in_valid is ignored while reset=1.
- Reset mid-operation: all in-flight beats are discarded. No result emerges for them.
- Latency: a beat accepted on edge t is presented with out_valid=1 immediately after edge t+STAGES−1. For STAGES=1, the result appears immediately after the accepting edge.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous events: with out_valid=1 and out_ready=1, the output beat retires and a new input beat is accepted on the same edge.
- Full pipeline plus out_ready=0: in_ready=0, and no beat is lost or duplicated.
- Ordering: results emerge strictly in acceptance order.
- Carries cross chunk boundaries only through stage registers. The combinational path per stage is one CW-bit ripple add.

## Test plan
- WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0x00000001, sub=0 -> after 4 edges, sum=0x00000000, carryout=1, zero=1, overflow=0.
- a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1, carryout=0. Also a=0x0000FFFF, b=1 -> sum=0x00010000, verifying the carry crosses a chunk boundary.
- Subtraction:
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, carryout=0, overflow=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, carryout=1, overflow=1.
- Streaming: 100 random beats with in_valid random and out_ready toggling pseudo-randomly. Required response:
  - every result matches a reference model, in order;
  - outputs are stable while stalled;
  - in_ready is low whenever out_valid && !out_ready.
- Reset mid-stream: issue 3 beats, then assert reset for 1 cycle -> out_valid stays 0 with no stale results emerging. A beat issued after reset returns after exactly STAGES edges.
- Configurations STAGES=1 and WIDTH=8/STAGES=8: same vectors scaled to width. Latency must be 1 and 8 cycles respectively, with full throughput.
